moore_zero_seq_detector: RTL and testbench
==========================================

// Module: moore_zero_seq_detector
// PURPOSE
//   Moore-type serial sequence detector: flags a 0 that follows a run of one
//   or more 1s on a single-bit input stream, sampled on rising clock edges.
//   Output depends only on present state, so it is glitch-free and one cycle
//   behind the input. Built structurally from two D flip-flops (A, B) plus
//   gate-level next-state and output logic. Both flip-flop states are exported
//   for observation and equivalence checking.
// PARAMETERS
//   none (fixed 2-bit state, 1-bit input/output)
// PORTS
//   clk    input   1  rising-edge clock
//   rst    input   1  asynchronous reset, active-low (0 = clear state)
//   x_in   input   1  serial data bit, sampled at posedge clk
//   y_out  output  1  detect flag; 1 while in state S2
//   A      output  1  state flip-flop A (MSB)
//   B      output  1  state flip-flop B (LSB)
// BEHAVIOUR
//   Encoding {A,B}: S0=00 idle/no 1 seen, S1=01 run of 1s seen,
//                   S2=10 0 after 1s (detect), S3=11 unused.
//   - Reset: rst=0 forces A=0, B=0, y_out=0 immediately. No clock needed.
//     The state holds while rst=0. Reset mid-run discards any partial run.
//   - On posedge clk with rst=1:
//       A <= B & ~x_in
//       B <= x_in
//   - Output: y_out = A & ~B. It is combinational from the state only.
//     It never depends on the current x_in.
//   - Transitions:
//       S0 x=0->S0  x=1->S1
//       S1 x=0->S2  x=1->S1
//       S2 x=0->S0  x=1->S1
//       S3 x=0->S2  x=1->S1, with y_out=0. S3 is unreachable from reset.
//         It exits in one clock, so the machine cannot lock up.
//   - Latency: y_out rises on the first clock edge that samples x_in=0 after a
//     sampled 1. It stays high for exactly one cycle unless re-triggered.
//   - Consecutive 1s keep the machine in S1 with no output.
//     Consecutive 0s in S0 give no output.
//   - Alternating 1,0,1,0 pulses y_out every second cycle.
//   - Release of rst asynchronous to clk is the system's responsibility.
//     The first edge after release uses the equations above from S0.
//   - Implementation: one D-FF primitive with async active-low clear,
//     instantiated twice. AND/NOT gate instances only for the logic.
//     No behavioural always-block FSM at the top level.
// TESTING
//   1. Reset: rst=0 with x_in toggling and clk running -> A=B=y_out=0
//      throughout. rst=1 then x=0 for 3 edges -> stays S0, y_out=0.
//   2. Basic detect: from S0 drive x=1,1,1,0 on successive edges ->
//      {A,B} = 01,01,01,10. y_out=1 only after the 4th edge. Then x=0 -> S0,
//      y_out=0.
//   3. Alternating: x toggles every clock starting at 1 (1,0,1,0,...) ->
//      y_out = 0,1,0,1,... after each edge. Check 8 edges.
//   4. Async reset mid-detect: in S2 (y_out=1), pull rst=0 between edges ->
//      y_out, A and B drop to 0 before the next edge. After release, x=0
//      gives no detect.
//   5. Illegal state: force {A,B}=11, then x=0 -> 10, y_out=1.
//      Separately, x=1 -> 01, y_out=0.
//   6. Equivalence: random x_in for 200 cycles against a behavioural
//      reference model. y_out must match on every cycle, and y_out must equal
//      A&~B at all times.

Source files
------------

// File: rtl/moore_zero_seq_detector_if.sv
// Serial bit stream into the zero-after-ones detector, plus the detect flag
// and both state flip-flops coming back out for observation.
interface moore_zero_seq_detector_if;
    logic x_in;
    logic y_out;
    logic A;
    logic B;

    // Stimulus side drives the data bit and watches the state and flag
    modport master (
        output x_in,
        input  y_out,
        input  A,
        input  B
    );

    // Detector side consumes the data bit and exports the state and flag
    modport slave (
        input  x_in,
        output y_out,
        output A,
        output B
    );
endinterface

// File: rtl/moore_zero_seq_detector.sv
// Moore detector that flags a 0 arriving after a run of one or more 1s.
// Built structurally: two D flip-flops with async active-low clear hold the
// state {A,B}, and AND/NOT gate primitives form the next-state and output
// logic. State encoding {A,B}: 00 idle, 01 ones seen, 10 detect, 11 unused.
// The unused code 11 behaves like 01 on the next edge (A <= B & ~x), so the
// machine always leaves it after one clock and cannot lock up.

// D flip-flop with asynchronous active-low clear
module moore_zero_seq_dff (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    // Capture d on each rising edge; clear immediately whenever clr_n is low
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

module moore_zero_seq_detector (
    input  logic                          clk,
    input  logic                          rst,
    moore_zero_seq_detector_if.slave      bus
);

    wire x_n;
    wire b_n;
    wire d_a;
    wire a_q;
    wire b_q;
    wire y_int;

    // A goes high only when the previous bit was 1 (B) and this bit is 0
    not u_not_x (x_n, bus.x_in);
    and u_and_da (d_a, b_q, x_n);

    // B simply remembers the last sampled bit
    moore_zero_seq_dff u_ff_a (
        .clk   (clk),
        .clr_n (rst),
        .d     (d_a),
        .q     (a_q)
    );

    moore_zero_seq_dff u_ff_b (
        .clk   (clk),
        .clr_n (rst),
        .d     (bus.x_in),
        .q     (b_q)
    );

    // Detect flag is decoded from the state alone, so it never sees x_in
    not u_not_b (b_n, b_q);
    and u_and_y (y_int, a_q, b_n);

    assign bus.y_out = y_int;
    assign bus.A     = a_q;
    assign bus.B     = b_q;

endmodule

// File: tb/tb_moore_zero_seq_detector.sv
// Self-checking bench for moore_zero_seq_detector. A transition-table model
// predicts {y_out,A,B} for each driven bit; predictions go through a queue
// and are compared once the DUT has clocked the bit in.
module tb_moore_zero_seq_detector;

    typedef struct packed {
        logic y;
        logic a;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    logic [1:0] model_state;
    int vectors = 0;
    int miscompares = 0;

    moore_zero_seq_detector_if bus ();

    moore_zero_seq_detector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Reference transition table written from the state diagram
    function automatic logic [1:0] ref_next(input logic [1:0] s, input logic x);
        logic [1:0] n;
        case (s)
            2'b00:   n = x ? 2'b01 : 2'b00;
            2'b01:   n = x ? 2'b01 : 2'b10;
            2'b10:   n = x ? 2'b01 : 2'b00;
            default: n = x ? 2'b01 : 2'b10;
        endcase
        return n;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.y = (model_state == 2'b10);
        e.a = model_state[1];
        e.b = model_state[0];
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_bit({tag, "_y"}, bus.y_out, e.y);
            check_bit({tag, "_A"}, bus.A, e.a);
            check_bit({tag, "_B"}, bus.B, e.b);
            check_bit({tag, "_y_eq_AnB"}, bus.y_out, bus.A & ~bus.B);
        end
    endtask

    // Drive one bit at the falling edge, predict, then sample 1 ns after the rising edge
    task automatic apply_stimulus(input logic x);
        @(negedge clk);
        bus.x_in = x;
        model_state = rst ? ref_next(model_state, x) : 2'b00;
        push_expected();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic x);
        apply_stimulus(x);
        check_output(tag);
    endtask

    // Load the unused code 11 between edges, then clock one bit from it
    task automatic illegal_state_step(input string tag, input logic x);
        @(negedge clk);
        force dut.u_ff_a.q = 1'b1;
        force dut.u_ff_b.q = 1'b1;
        #1;
        model_state = 2'b11;
        push_expected();
        check_output({tag, "_s3"});
        release dut.u_ff_a.q;
        release dut.u_ff_b.q;
        bus.x_in = x;
        model_state = ref_next(model_state, x);
        push_expected();
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        rst = 1'b0;
        bus.x_in = 1'b0;
        model_state = 2'b00;
        #1;
        push_expected();
        check_output("reset_t0");

        // Reset held with x toggling and the clock running
        for (int i = 0; i < 4; i++) begin
            step("reset_hold", (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Release reset and idle on zeros
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("idle_zero", 1'b0);
        end

        // Basic detect: 1,1,1,0 then 0
        step("basic_1a", 1'b1);
        step("basic_1b", 1'b1);
        step("basic_1c", 1'b1);
        step("basic_0", 1'b0);
        step("basic_back", 1'b0);

        // Alternating pattern starting at 1
        for (int i = 0; i < 8; i++) begin
            step("alternating", (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        step("alt_settle", 1'b0);

        // Async reset while in detect state, between edges
        step("async_pre1", 1'b1);
        step("async_pre0", 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_state = 2'b00;
        push_expected();
        check_output("async_clear");
        @(negedge clk);
        rst = 1'b1;
        step("async_after", 1'b0);

        // Unused state exits in one clock
        illegal_state_step("illegal_x0", 1'b0);
        step("illegal_settle", 1'b0);
        illegal_state_step("illegal_x1", 1'b1);
        step("illegal_settle2", 1'b0);

        // Random stream against the reference model
        for (int i = 0; i < 200; i++) begin
            step("random", 1'($urandom_range(0, 1)));
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
